ttl_latch_fifo: RTL and testbench
=================================

TTL_LATCH_FIFO -- requirements
Module: ttl_latch_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of stored words, power of two (>=2).
REQ-003 Port list (name, direction, width, meaning):
- clk, input, 1, sole clock, rising-edge active.
- rst, input, 1, synchronous, active-high reset.
- d, input, WIDTH, write data.
- wr, input, 1, write strobe, sampled on clk rise.
- rd, input, 1, read strobe, sampled on clk rise.
- oe, input, 1, output enable, active-low; 1 = q high-Z.
- q, output, WIDTH, tri-state data output.
- empty, output, 1, no words stored.
- full, output, 1, DEPTH words stored.
- count, output, clog2(DEPTH)+1, words stored.
- err, output, 1, sticky overflow/underflow flag.
REQ-004 One clock; reset is synchronous and active-high; ports named clk and rst.

Function
REQ-005 Storage SHALL be a DEPTH x WIDTH circular buffer with write pointer, read pointer and count, all updated only on clk rise.
REQ-006 Accepted write (wr=1, full=0): d SHALL be stored at write pointer, pointer advances, wrapping DEPTH-1 -> 0.
REQ-007 Accepted read (rd=1, empty=0): read pointer SHALL advance with the same wrap rule; the word is discarded.
REQ-008 q SHALL be first-word-fall-through: with oe=0 and empty=0, q equals the oldest stored word combinationally, zero cycles after the write edge that made it oldest.
REQ-009 With oe=1, q SHALL be high-Z on all bits regardless of any other input or state.
REQ-010 With oe=0 and empty=1, q SHALL follow REQ-020/REQ-021.
REQ-011 count SHALL be +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-012 empty = (count==0); full = (count==DEPTH); both combinational from count.
REQ-013 wr=1 with rd=1 when empty: write accepted, read ignored (no bypass through storage), err unchanged.
REQ-014 wr=1 with rd=1 when full: both accepted, count stays DEPTH, err unchanged.
REQ-015 wr=1 with rd=0 when full: write rejected, contents unchanged, err set to 1.
REQ-016 rd=1 with wr=0 when empty: read ignored, err set to 1.
REQ-017 err SHALL stay 1 until reset; no other clear path.
REQ-018 oe SHALL not affect storage, pointers, count, flags or err.

Reset
REQ-019 rst=1 at clk rise SHALL set pointers=0, count=0, empty=1, full=0, err=0, overriding wr/rd that cycle; memory contents need not be cleared; reset mid-stream discards all stored words.

Configuration
REQ-020 Macro TTL_LATCH_FIFO_TRANSPARENT_EN defined: with oe=0 and empty=1, q SHALL pass d combinationally (transparent-latch behaviour); storage and flags unaffected.
REQ-021 Macro undefined: with oe=0 and empty=1, q SHALL drive all zeros.

Verification
REQ-022 Reset then oe=0, no strobes -> empty=1, full=0, count=0, err=0, q=0 (macro undefined) or q=d (macro defined).
REQ-023 WIDTH=8, DEPTH=4: write 8'hFF, 8'hAA, 8'h33, 8'hCC -> full=1, count=4, q=8'hFF; four reads -> q steps FF, AA, 33, CC, then empty=1.
REQ-024 Full FIFO, wr=1 rd=0 with d=8'h55 -> err=1, count=4, 8'h55 never appears on q; reads return the original four words.
REQ-025 Wrap: 6 writes interleaved with 6 reads on DEPTH=4 (pointers cross 3 -> 0) -> read order matches write order; simultaneous wr/rd when full keeps count=4; wr/rd when empty leaves count=1, err=0.
REQ-026 Two words stored, oe=1 -> q=8'hzz; oe=0 -> oldest word; rst=1 for one edge -> empty=1, err=0, count=0.

Source files
------------

// File: rtl/ttl_latch_fifo.sv
// ttl_latch_fifo: first-word-fall-through circular FIFO with an active-low tri-state output and a sticky err flag.
// Define TTL_LATCH_FIFO_TRANSPARENT_EN to pass d straight to q while the FIFO is empty (otherwise q is zero when empty).
module ttl_latch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d,
  input  logic                   wr,
  input  logic                   rd,
  input  logic                   oe,
  output logic [WIDTH-1:0]       q,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             err_reg;
  logic             err_next;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] empty_word;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_FULL);
  assign count = count_reg;
  assign err   = err_reg;

  // A write into a full FIFO is only legal when the oldest word leaves on the same edge.
  assign wr_ok = wr && (!full || rd);
  assign rd_ok = rd && !empty;

  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    if (wr_ok && !rd_ok) begin
      count_next = count_reg + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_next = count_reg - CNT_ONE;
    end
    if ((wr && !rd && full) || (rd && !wr && empty)) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wptr_reg] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr_reg <= wptr_reg + PTR_ONE;
      end
      if (rd_ok) begin
        rptr_reg <= rptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

`ifdef TTL_LATCH_FIFO_TRANSPARENT_EN
  assign empty_word = d;
`else
  assign empty_word = '0;
`endif

  assign q = oe ? {WIDTH{1'bz}} : (empty ? empty_word : mem[rptr_reg]);

endmodule

// File: tb/tb_ttl_latch_fifo.sv
// tb_ttl_latch_fifo: directed plus randomized checks of ttl_latch_fifo (WIDTH=8, DEPTH=4) against a queue model.
// q is observed through a pulled-up net, so a released bus reads as all ones.
module tb_ttl_latch_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] d   = '0;
  logic             wr  = 1'b0;
  logic             rd  = 1'b0;
  logic             oe  = 1'b1;
  tri1  [WIDTH-1:0] q;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] mq [$];
  bit         merr = 1'b0;
  bit         wacc;
  bit         racc;

  ttl_latch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .d(d), .wr(wr), .rd(rd), .oe(oe),
    .q(q), .empty(empty), .full(full), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of stored words; acceptance decided from occupancy only.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      racc = rd && (mq.size() > 0);
      wacc = wr && ((mq.size() < DEPTH) || rd);
      if (wr && !rd && mq.size() == DEPTH) merr = 1'b1;
      if (rd && !wr && mq.size() == 0)     merr = 1'b1;
      if (racc) void'(mq.pop_front());
      if (wacc) mq.push_back(d);
    end
  end

  always @(negedge clk) begin
    logic [7:0] eq;
    if (chk_en) begin
      if (oe) eq = 8'hFF;
      else if (mq.size() == 0) begin
`ifdef TTL_LATCH_FIFO_TRANSPARENT_EN
        eq = d;
`else
        eq = 8'h00;
`endif
      end else eq = mq[0];
      check("q", q, eq);
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("err", err, merr);
    end
  end

  task automatic step(input logic w, input logic r, input logic o, input logic [7:0] dv);
    wr = w; rd = r; oe = o; d = dv;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] pat [4] = '{8'hFF, 8'hAA, 8'h33, 8'hCC};
  logic [7:0] v;
  int bias;

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    step(0, 0, 0, 8'h5A);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
`ifdef TTL_LATCH_FIFO_TRANSPARENT_EN
    check("rst_q", q, 8'h5A);
`else
    check("rst_q", q, 8'h00);
`endif

    // Fill and drain in order
    for (int i = 0; i < 4; i++) step(1, 0, 0, pat[i]);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_q", q, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      check("drain_q", q, pat[i]);
      step(0, 1, 0, 8'h00);
    end
    check("drain_empty", empty, 1);

    // Overflow attempt
    for (int i = 0; i < 4; i++) step(1, 0, 0, pat[i]);
    step(1, 0, 0, 8'h55);
    check("ovf_err", err, 1);
    check("ovf_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_q", q, pat[i]);
      step(0, 1, 0, 8'h00);
    end

    // Pointer wrap with interleaved traffic
    rst = 1'b1; step(0, 0, 0, 8'h00); rst = 1'b0;
    check("wrap_err0", err, 0);
    step(1, 0, 0, 8'h10);
    for (int i = 1; i <= 6; i++) begin
      v = 8'h10 + 8'(i);
      step(1, 0, 0, v);
      check("wrap_q", q, 8'h10 + 8'(i - 1));
      step(0, 1, 0, 8'h00);
    end
    step(0, 1, 0, 8'h00);
    check("wrap_empty", empty, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h20 + 8'(i));
    step(1, 1, 0, 8'h77);
    check("fullrw_count", count, 4);
    check("fullrw_err", err, 0);
    check("fullrw_q", q, 8'h21);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
    check("emptyrw_empty", empty, 1);
    step(1, 1, 0, 8'h99);
    check("emptyrw_count", count, 1);
    check("emptyrw_err", err, 0);
    check("emptyrw_q", q, 8'h99);

    // Output enable and mid-stream reset
    rst = 1'b1; step(0, 0, 0, 8'h00); rst = 1'b0;
    step(0, 1, 0, 8'h00);
    check("unf_err", err, 1);
    step(1, 0, 0, 8'hA1);
    step(1, 0, 0, 8'hB2);
    step(0, 0, 1, 8'h00);
    check("oe_hiz", q, 8'hFF);
    step(0, 0, 0, 8'h00);
    check("oe_q", q, 8'hA1);
    rst = 1'b1; step(1, 1, 0, 8'h00); rst = 1'b0;
    check("mrst_empty", empty, 1);
    check("mrst_err", err, 0);
    check("mrst_count", count, 0);

    // Randomized traffic with drifting fill bias
    for (int i = 0; i < 3000; i++) begin
      bias = (i / 300) % 3;
      rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 9) < (bias == 0 ? 7 : bias == 1 ? 5 : 3)),
           ($urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 5 : 7)),
           ($urandom_range(0, 4) == 0),
           8'($urandom()));
    end
    rst = 1'b0;
    step(0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
